// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter, plus the word/address width
// macros (normally from constants.svh; defined here only when not already present).
`ifndef PADDRSIZE
`define PADDRSIZE 22
`endif
`ifndef PADDR
`define PADDR [`PADDRSIZE-1:0]
`endif
`ifndef WORD
`define WORD [35:0]
`endif

package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker: one-hot pick, ties go to the port that did not win last
// (or always to port 0 when FIXED_PRIO is set).
module mem_arb_pick #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick
);
  always_comb begin
    pick = req;
    if (req == 2'b11)
      pick = (FIXED_PRIO || last_grant) ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single memory: one mem strobe per transaction, ack routed
// back to the granted port. Define MEM_NXM_EN to add the nonexistent-memory timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int NXM_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic `PADDR  p0_addr,
  input  logic `WORD   p0_write_data,
  input  logic         p0_read,
  input  logic         p0_write,
  output logic `WORD   p0_read_data,
  output logic         p0_read_ack,
  output logic         p0_write_ack,
  input  logic `PADDR  p1_addr,
  input  logic `WORD   p1_write_data,
  input  logic         p1_read,
  input  logic         p1_write,
  output logic `WORD   p1_read_data,
  output logic         p1_read_ack,
  output logic         p1_write_ack,
  output logic `PADDR  mem_addr,
  output logic `WORD   mem_write_data,
  output logic         mem_read,
  output logic         mem_write,
  input  logic `WORD   mem_read_data,
  input  logic         mem_read_ack,
  input  logic         mem_write_ack,
  output logic [1:0]   grant
`ifdef MEM_NXM_EN
  ,
  output logic         p0_nxm,
  output logic         p1_nxm
`endif
);
  if (NXM_CYCLES < 1) begin : g_bad_nxm
    $error("NXM_CYCLES must be at least 1");
  end

  state_t     state, state_nx;
  op_t        op, op_nx;
  logic       last_grant;
  logic [1:0] req, pick;
  logic       busy, ack_hit, done, timeout;

  assign req = {p1_read | p1_write, p0_read | p0_write};

  mem_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick)
  );

  always_comb begin
    state_nx = state;
    busy     = !reset && (state == ISSUE || state == WAIT);
    ack_hit  = (op == OP_WRITE) ? mem_write_ack : mem_read_ack;
    done     = busy && (ack_hit || timeout);
    // write wins when a port raises both strobes
    if (pick[1]) op_nx = p1_write ? OP_WRITE : OP_READ;
    else         op_nx = p0_write ? OP_WRITE : OP_READ;
    case (state)
      IDLE:    if (|pick) state_nx = ISSUE;
      ISSUE:   state_nx = done ? IDLE : WAIT;
      WAIT:    if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef MEM_NXM_EN
  localparam int CNT_W = $clog2(NXM_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  // fires in the NXM_CYCLES-th WAIT cycle that still has no matching ack
  assign timeout = !reset && state == WAIT && !ack_hit &&
                   wait_cnt == CNT_W'(NXM_CYCLES - 1);
  assign p0_nxm  = timeout && grant[0];
  assign p1_nxm  = timeout && grant[1];
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant          <= 2'b00;
      last_grant     <= 1'b1;
      op             <= OP_READ;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if (state == IDLE && |pick) begin
        grant          <= pick;
        last_grant     <= pick[1];
        op             <= op_nx;
        mem_addr       <= pick[1] ? p1_addr : p0_addr;
        mem_write_data <= pick[1] ? p1_write_data : p0_write_data;
        mem_read       <= (op_nx == OP_READ);
        mem_write      <= (op_nx == OP_WRITE);
      end else if (done) begin
        grant <= 2'b00;
      end
    end
  end

  assign p0_read_ack  = done && grant[0] && op == OP_READ;
  assign p0_write_ack = done && grant[0] && op == OP_WRITE;
  assign p1_read_ack  = done && grant[1] && op == OP_READ;
  assign p1_write_ack = done && grant[1] && op == OP_WRITE;
  assign p0_read_data = (timeout && grant[0]) ? '0 : mem_read_data;
  assign p1_read_data = (timeout && grant[1]) ? '0 : mem_read_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with a switchable registered/immediate
// memory, plus a FIXED_PRIO=1 instance for the fixed-priority contention case.
`ifndef PADDRSIZE
`define PADDRSIZE 22
`endif
`ifndef PADDR
`define PADDR [`PADDRSIZE-1:0]
`endif
`ifndef WORD
`define WORD [35:0]
`endif

module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // round-robin instance
  logic `PADDR p0_addr, p1_addr, mem_addr;
  logic `WORD  p0_write_data, p1_write_data, p0_read_data, p1_read_data;
  logic `WORD  mem_write_data, mem_read_data;
  logic p0_read, p0_write, p0_read_ack, p0_write_ack;
  logic p1_read, p1_write, p1_read_ack, p1_write_ack;
  logic mem_read, mem_write, mem_read_ack, mem_write_ack;
  logic [1:0] grant;
  // fixed-priority instance
  logic `PADDR f_p0_addr, f_p1_addr, f_mem_addr;
  logic `WORD  f_p0_write_data, f_p1_write_data, f_p0_read_data, f_p1_read_data;
  logic `WORD  f_mem_write_data, f_mem_read_data;
  logic f_p0_read, f_p0_write, f_p0_read_ack, f_p0_write_ack;
  logic f_p1_read, f_p1_write, f_p1_read_ack, f_p1_write_ack;
  logic f_mem_read, f_mem_write, f_mem_read_ack, f_mem_write_ack;
  logic [1:0] f_grant;
`ifdef MEM_NXM_EN
  logic p0_nxm, p1_nxm, f_p0_nxm, f_p1_nxm;
`endif

  mem_arbiter #(.FIXED_PRIO(1'b0), .NXM_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .p0_addr(p0_addr), .p0_write_data(p0_write_data), .p0_read(p0_read), .p0_write(p0_write),
    .p0_read_data(p0_read_data), .p0_read_ack(p0_read_ack), .p0_write_ack(p0_write_ack),
    .p1_addr(p1_addr), .p1_write_data(p1_write_data), .p1_read(p1_read), .p1_write(p1_write),
    .p1_read_data(p1_read_data), .p1_read_ack(p1_read_ack), .p1_write_ack(p1_write_ack),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack),
    .mem_write_ack(mem_write_ack), .grant(grant)
`ifdef MEM_NXM_EN
    , .p0_nxm(p0_nxm), .p1_nxm(p1_nxm)
`endif
  );

  mem_arbiter #(.FIXED_PRIO(1'b1), .NXM_CYCLES(16)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_addr(f_p0_addr), .p0_write_data(f_p0_write_data), .p0_read(f_p0_read),
    .p0_write(f_p0_write), .p0_read_data(f_p0_read_data), .p0_read_ack(f_p0_read_ack),
    .p0_write_ack(f_p0_write_ack),
    .p1_addr(f_p1_addr), .p1_write_data(f_p1_write_data), .p1_read(f_p1_read),
    .p1_write(f_p1_write), .p1_read_data(f_p1_read_data), .p1_read_ack(f_p1_read_ack),
    .p1_write_ack(f_p1_write_ack),
    .mem_addr(f_mem_addr), .mem_write_data(f_mem_write_data), .mem_read(f_mem_read),
    .mem_write(f_mem_write), .mem_read_data(f_mem_read_data), .mem_read_ack(f_mem_read_ack),
    .mem_write_ack(f_mem_write_ack), .grant(f_grant)
`ifdef MEM_NXM_EN
    , .p0_nxm(f_p0_nxm), .p1_nxm(f_p1_nxm)
`endif
  );

  // memory model: registered ack by default, immediate when imm=1, silent when mute=1
  logic `WORD mem [0:1023];
  logic `WORD rdata_q;
  logic rack_q, wack_q, imm, mute, inj_rack, pl_en;
  logic [9:0] pl_addr;
  logic `WORD pl_data;
  always @(posedge clk) begin
    rack_q  <= mem_read & ~mute;
    wack_q  <= mem_write & ~mute;
    rdata_q <= mem[mem_addr[9:0]];
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write & ~mute) mem[mem_addr[9:0]] <= mem_write_data;
  end
  assign mem_read_ack  = imm ? (mem_read & ~mute)  : (rack_q | inj_rack);
  assign mem_write_ack = imm ? (mem_write & ~mute) : wack_q;
  assign mem_read_data = imm ? mem[mem_addr[9:0]] : rdata_q;

  logic f_rack_q, f_wack_q;
  always @(posedge clk) begin
    f_rack_q <= f_mem_read;
    f_wack_q <= f_mem_write;
  end
  assign f_mem_read_ack  = f_rack_q;
  assign f_mem_write_ack = f_wack_q;
  assign f_mem_read_data = '0;

  // any mem_write high two cycles running is a violation
  logic prev_mw = 1'b0;
  int   wide_err = 0;
  always @(negedge clk) begin
    prev_mw <= mem_write;
    if (mem_write && prev_mw) wide_err <= wide_err + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick; @(posedge clk); #1; endtask
  task automatic smp;  @(negedge clk);     endtask

  task automatic preload(input logic [9:0] a, input logic `WORD d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic pulse_reset;
    tick; reset = 1'b1;
    tick; reset = 1'b0;
  endtask

  initial begin
    int acks, fp0, fp1, rdp, mask, npulse, fnpulse;
    logic [7:0] seq, fseq;
    logic `WORD first_data;

    reset = 1'b1; imm = 1'b0; mute = 1'b0; inj_rack = 1'b0; pl_en = 1'b0;
    pl_addr = '0; pl_data = '0;
    p0_addr = '0; p0_write_data = '0; p0_read = 1'b0; p0_write = 1'b0;
    p1_addr = '0; p1_write_data = '0; p1_read = 1'b0; p1_write = 1'b0;
    f_p0_addr = '0; f_p0_write_data = '0; f_p0_read = 1'b0; f_p0_write = 1'b0;
    f_p1_addr = '0; f_p1_write_data = '0; f_p1_read = 1'b0; f_p1_write = 1'b0;
    tick; tick;
    smp;
    chk("rst grant", grant, 2'b00);
    chk("rst mem_read", mem_read, 1'b0);
    chk("rst mem_write", mem_write, 1'b0);
    chk("rst acks", {p0_read_ack, p0_write_ack, p1_read_ack, p1_write_ack}, 4'b0000);
    preload(10'd512, 36'o123456701234);
    tick; reset = 1'b0;

    // single registered-ack read on p0
    tick; p0_addr = 22'o1000; p0_read = 1'b1;
    smp;  chk("t1 c0 mem_read", mem_read, 1'b0);
    tick; smp;
    chk("t1 c1 mem_read", mem_read, 1'b1);
    chk("t1 c1 mem_addr", mem_addr, 22'o1000);
    chk("t1 c1 grant", grant, 2'b01);
    chk("t1 c1 early ack", p0_read_ack, 1'b0);
    tick; smp;
    chk("t1 c2 ack", p0_read_ack, 1'b1);
    chk("t1 c2 data", p0_read_data, 36'o123456701234);
    chk("t1 c2 mem_read low", mem_read, 1'b0);
    tick; p0_read = 1'b0;
    smp;
    chk("t1 c3 grant", grant, 2'b00);

    // round-robin write contention
    pulse_reset;
    tick;
    p0_addr = 22'o2000; p0_write_data = 36'o111111111111; p0_write = 1'b1;
    p1_addr = 22'o2001; p1_write_data = 36'o222222222222; p1_write = 1'b1;
    acks = 0; seq = '0; npulse = 0;
    for (int n = 0; n < 40; n++) begin
      smp;
      if (mem_write) begin seq = {seq[5:0], grant}; npulse++; end
      if (p0_write_ack || p1_write_ack) acks++;
      if (acks == 4) break;
      tick;
    end
    tick; p0_write = 1'b0; p1_write = 1'b0;
    chk("t2 acks", acks, 4);
    chk("t2 pulses", npulse, 4);
    chk("t2 grant order", seq, 8'h66);
    tick; tick; smp;
    chk("t2 mem p0", mem[0], 36'o111111111111);
    chk("t2 mem p1", mem[1], 36'o222222222222);

    // fixed-priority contention
    tick;
    f_p0_addr = 22'o10; f_p0_write = 1'b1;
    f_p1_addr = 22'o20; f_p1_write = 1'b1;
    fp0 = 0; fp1 = 0; fseq = '0; fnpulse = 0;
    for (int n = 0; n < 60; n++) begin
      smp;
      if (f_mem_write) begin fseq = {fseq[5:0], f_grant}; fnpulse++; end
      if (f_p0_write_ack) fp0++;
      if (f_p1_write_ack) fp1++;
      tick;
      if (fp0 == 3) f_p0_write = 1'b0;
      if (fp1 == 1) begin f_p1_write = 1'b0; break; end
    end
    f_p0_write = 1'b0; f_p1_write = 1'b0;
    chk("t3 p0 acks", fp0, 3);
    chk("t3 p1 acks", fp1, 1);
    chk("t3 pulses", fnpulse, 4);
    chk("t3 grant order", fseq, 8'h56);

    // immediate-ack back-to-back reads on p1
    preload(10'd516, 36'o777000111222);
    imm = 1'b1;
    tick; p1_addr = 22'o1004; p1_read = 1'b1;
    acks = 0; rdp = 0; mask = 0; first_data = '0;
    for (int n = 0; n < 20; n++) begin
      smp;
      if (mem_read) rdp++;
      if (p1_read_ack) begin
        if (acks == 0) first_data = p1_read_data;
        acks++;
        mask = mask | (1 << n);
      end
      if (acks == 3) break;
      tick;
    end
    tick; p1_read = 1'b0;
    for (int n = 0; n < 3; n++) begin
      smp;
      if (mem_read) rdp++;
      tick;
    end
    chk("t4 acks", acks, 3);
    chk("t4 ack cycles", mask, 32'h2A);
    chk("t4 mem_read count", rdp, 3);
    chk("t4 data", first_data, 36'o777000111222);
    imm = 1'b0;

    // reset while a p0 read waits; acks during and after reset must be dropped
    mute = 1'b1;
    tick; p0_addr = 22'o1000; p0_read = 1'b1;
    tick; smp; chk("t5 issue", mem_read, 1'b1);
    tick; reset = 1'b1; p0_read = 1'b0; inj_rack = 1'b1;
    smp;  chk("t5 ack in reset", p0_read_ack, 1'b0);
    tick; reset = 1'b0;
    smp;
    chk("t5 late ack", p0_read_ack, 1'b0);
    chk("t5 grant", grant, 2'b00);
    chk("t5 mem strobes", {mem_read, mem_write}, 2'b00);
    tick; inj_rack = 1'b0; mute = 1'b0;

`ifdef MEM_NXM_EN
    // nonexistent memory on p1, then a normal p0 read
    preload(10'd520, 36'o555555555555);
    mute = 1'b1;
    tick; p1_addr = 22'o1010; p1_read = 1'b1;
    repeat (16) tick;
    smp;
    chk("t6 nxm early", p1_nxm, 1'b0);
    chk("t6 ack early", p1_read_ack, 1'b0);
    tick; smp;
    chk("t6 nxm", p1_nxm, 1'b1);
    chk("t6 ack", p1_read_ack, 1'b1);
    chk("t6 data zero", p1_read_data, 36'o0);
    chk("t6 p0 nxm", p0_nxm, 1'b0);
    tick; p1_read = 1'b0; mute = 1'b0;
    smp; chk("t6 idle grant", grant, 2'b00);
    tick; p0_addr = 22'o1000; p0_read = 1'b1;
    tick; tick; smp;
    chk("t6 p0 ack", p0_read_ack, 1'b1);
    chk("t6 p0 data", p0_read_data, 36'o123456701234);
    chk("t6 p0 nxm clear", p0_nxm, 1'b0);
    tick; p0_read = 1'b0;
`endif

    tick; smp;
    chk("mem_write width", wide_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single physical memory (the `mem` block) between the CPU (port 0) and a second master (port 1: console/DMA/IO).
- Serialises requests and issues exactly one single-cycle mem_read or mem_write pulse per transaction.
- Routes the memory's ack back to the granted port.
- Works with both registered-ack and immediate-ack memory builds.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 0 always wins a tie.
- NXM_CYCLES, 16: WAIT-state cycle limit before nonexistent-memory timeout (used only with MEM_NXM_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p0_addr  in  `PADDR  port 0 physical address
- p0_write_data  in  `WORD  port 0 store data
- p0_read  in  1  port 0 read request (level, held until ack)
- p0_write  in  1  port 0 write request (level, held until ack)
- p0_read_data  out  `WORD  read data, valid only while p0_read_ack=1
- p0_read_ack  out  1  port 0 read complete (one-cycle pulse)
- p0_write_ack  out  1  port 0 write complete (one-cycle pulse)
- p1_addr, p1_write_data, p1_read, p1_write, p1_read_data, p1_read_ack, p1_write_ack: same as port 0, for port 1
- mem_addr  out  `PADDR  to memory
- mem_write_data  out  `WORD  to memory
- mem_read  out  1  one-cycle read strobe
- mem_write  out  1  one-cycle write strobe
- mem_read_data  in  `WORD  from memory
- mem_read_ack  in  1  from memory
- mem_write_ack  in  1  from memory
- grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high.
- Reset values: state=IDLE; grant=00; mem_read=0; mem_write=0; all port acks=0; last_grant=1, so port 0 wins the first tie.
- Registered outputs: mem_addr, mem_write_data, mem_read, mem_write, grant.
- Combinational outputs: port acks and read_data.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Sample p0/p1 requests. Priority is round-robin: on a tie, grant the port not equal to last_grant (FIXED_PRIO=1: port 0).
  - On grant: latch addr/data/op into mem_* registers, set grant, update last_grant, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - mem_read or mem_write is high for exactly this one cycle.
  - If the matching mem ack is present this cycle (immediate-ack memory): forward the ack and go to IDLE. Otherwise go to WAIT.
- WAIT:
  - mem_read and mem_write are low. Hold until the matching mem ack arrives, forward it, then go to IDLE.
- Ack forwarding:
  - pN_read_ack = mem_read_ack & grant[N] & op==read & state∈{ISSUE,WAIT}; write_ack is analogous.
  - Acks arriving in IDLE, or of the wrong type, are ignored.
- Read data: pN_read_data = mem_read_data (shared passthrough). Content is defined only in that port's read_ack cycle.
- Latency (registered-ack memory): request first seen in cycle t → mem_read in t+1 → port ack in t+2. Immediate-ack memory: ack in t+1.
- Back-to-back: the arbiter returns to IDLE the cycle after ack. A request still high in that cycle is a new transaction, so a registered requester must drop its request at the edge after its ack.
- Both read and write on one port: treated as a write; the read is ignored.
- Requester contract: addr/data/op must be stable from request until ack. The arbiter latches them at grant, so later changes do not affect the granted transaction.
- Reset mid-transaction: abort to IDLE. Late mem acks are ignored; no port ack is generated.
- No starvation: under continuous contention in round-robin mode, grants alternate p0, p1, p0, ...

Optional Feature:
- Macro: MEM_NXM_EN.
- Defined:
  - Adds outputs p0_nxm and p1_nxm (1 bit each, reset 0) and a WAIT-cycle counter.
  - If WAIT lasts NXM_CYCLES cycles with no matching ack, the arbiter asserts pN_nxm together with the pending pN_read_ack/pN_write_ack for one cycle, forces pN_read_data=0 in that cycle, and goes to IDLE.
  - The memory must never ack a transaction after the timeout.
- Undefined: no counter, no nxm ports; WAIT waits indefinitely.

Decomposition:
- `PADDR, `WORD and `PADDRSIZE come from constants.svh.
- New package mem_arb_pkg holds the state enum (IDLE, ISSUE, WAIT) and the op typedef (OP_READ, OP_WRITE).
- One sub-module: mem_arb_pick, combinational two-way priority picker (inputs: req[1:0], last_grant, FIXED_PRIO; output: one-hot pick).

Test Plan:
1. Single read on p0, addr 'o1000, registered-ack memory holding 36'o123456701234 → mem_read pulses in cycle t+1, p0_read_ack and p0_read_data=36'o123456701234 in cycle t+2, grant back to 00 in t+3.
2. p0 and p1 write simultaneously and continuously (FIXED_PRIO=0) → grants alternate p0, p1, p0, p1. Each mem_write is exactly 1 cycle wide. Memory contents match both writes.
3. Same contention with FIXED_PRIO=1 → p0 is served every slot until it drops its request; p1 is served only then.
4. Immediate-ack memory, back-to-back p1 reads → each ack arrives in the ISSUE cycle; one transaction every 2 cycles; no duplicate mem_read.
5. reset asserted in WAIT while a p0 read is pending, then a mem_read_ack arrives next cycle → no p0_read_ack; all outputs at reset values.
6. MEM_NXM_EN, NXM_CYCLES=16, p1 read, memory never acks → p1_nxm=1, p1_read_ack=1 and p1_read_data=0 after 16 WAIT cycles; a subsequent p0 read completes normally.
